seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver_pkg.sv | 32 +++
 rtl/seg_scan_driver_if.sv | 24 ++
 rtl/seg_scan_driver_font.sv | 27 ++
 rtl/seg_scan_driver.sv | 108 ++++++++++
 tb/tb_seg_scan_driver.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the multiplexed 8-digit seven-segment scanner.
// Font patterns are active-low {g,f,e,d,c,b,a}.
package seg_scan_driver_pkg;

    typedef enum logic [0:0] {
        StShow,
        StDead
    } state_e;

    localparam logic [3:0] MINUS = 4'hA;

    localparam logic [6:0] FONT_0     = 7'h40;
    localparam logic [6:0] FONT_1     = 7'h79;
    localparam logic [6:0] FONT_2     = 7'h24;
    localparam logic [6:0] FONT_3     = 7'h30;
    localparam logic [6:0] FONT_4     = 7'h19;
    localparam logic [6:0] FONT_5     = 7'h12;
    localparam logic [6:0] FONT_6     = 7'h02;
    localparam logic [6:0] FONT_7     = 7'h78;
    localparam logic [6:0] FONT_8     = 7'h00;
    localparam logic [6:0] FONT_9     = 7'h10;
    localparam logic [6:0] FONT_MINUS = 7'h3F;
    localparam logic [6:0] FONT_BLANK = 7'h7F;

    // nib holds digit n in bits [4n+3:4n]: temperature in digits 7..4, humidity in 3..0.
    typedef struct packed {
        logic [31:0] nib;
        logic [7:0]  dat_en;
        logic [7:0]  dot_en;
    } disp_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Data-load and display-drive signals of the seg_scan_driver.
// The master loads digits and observes the display; the slave is the driver.
interface seg_scan_driver_if;

    logic [15:0] T_data;
    logic [15:0] H_data;
    logic [7:0]  dat_en;
    logic [7:0]  dot_en;
    logic        data_vld;
    logic [7:0]  seg_sel;
    logic [7:0]  seg_led;
    logic        frame_done;

    modport master (
        output T_data, H_data, dat_en, dot_en, data_vld,
        input  seg_sel, seg_led, frame_done
    );

    modport slave (
        input  T_data, H_data, dat_en, dot_en, data_vld,
        output seg_sel, seg_led, frame_done
    );

endinterface

// File: rtl/seg_scan_driver_font.sv
// Combinational nibble to active-low seven-segment pattern decode.
module seg_font
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = FONT_BLANK;
        case (nibble_i)
            4'h0:    seg_o = FONT_0;
            4'h1:    seg_o = FONT_1;
            4'h2:    seg_o = FONT_2;
            4'h3:    seg_o = FONT_3;
            4'h4:    seg_o = FONT_4;
            4'h5:    seg_o = FONT_5;
            4'h6:    seg_o = FONT_6;
            4'h7:    seg_o = FONT_7;
            4'h8:    seg_o = FONT_8;
            4'h9:    seg_o = FONT_9;
            MINUS:   seg_o = FONT_MINUS;
            default: seg_o = FONT_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Scans eight digits 7..0 with a blanking tail per slot; new data is double-buffered
// so the displayed frame only changes at the digit 0 -> digit 7 wrap.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 12_000_000,
    parameter int unsigned SCAN_HZ  = 1000,
    parameter int unsigned DEAD_CYC = 12
) (
    input logic               clk,
    input logic               rst_n,
    seg_scan_driver_if.slave  bus
);

    localparam int unsigned SCAN_CNT = CLK_FREQ / SCAN_HZ;
    localparam int unsigned CNT_W    = $clog2(SCAN_CNT);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_CNT - DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_CNT - 1);

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    disp_t            shadow_q, shadow_d, pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [7:0]       sel_q, sel_d, led_q, led_d;
    logic             fd_q, fd_d;

    disp_t      in_w;
    logic [3:0] cur_nib;
    logic [6:0] font;
    logic       slot_end, frame_end;

    assign in_w      = '{nib: {bus.T_data, bus.H_data}, dat_en: bus.dat_en, dot_en: bus.dot_en};
    assign cur_nib   = shadow_q.nib[{idx_q, 2'b00} +: 4];
    assign slot_end  = (state_q == StDead) && (cnt_q == SLOT_LAST);
    assign frame_end = slot_end && (idx_q == 3'd0);

    seg_font u_font (
        .nibble_i (cur_nib),
        .seg_o    (font)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = slot_end ? '0 : cnt_q + CNT_W'(1);
        unique case (state_q)
            StShow: if (cnt_q == SHOW_LAST) state_d = StDead;
            StDead: begin
                if (slot_end) begin
                    state_d = StShow;
                    idx_d   = idx_q - 3'd1;
                end
            end
            default: state_d = StShow;
        endcase

        // A load landing on the boundary cycle bypasses pending and goes straight to shadow.
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (frame_end) begin
            pend_vld_d = 1'b0;
            if (bus.data_vld)    shadow_d = in_w;
            else if (pend_vld_q) shadow_d = pend_q;
        end else if (bus.data_vld) begin
            pend_d     = in_w;
            pend_vld_d = 1'b1;
        end

        fd_d  = frame_end;
        sel_d = 8'hFF;
        led_d = 8'hFF;
        if (state_q == StShow) begin
            sel_d = ~(8'b1 << idx_q);
            led_d = {~shadow_q.dot_en[idx_q], shadow_q.dat_en[idx_q] ? font : FONT_BLANK};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StShow;
            idx_q      <= 3'd7;
            cnt_q      <= '0;
            shadow_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            sel_q      <= 8'hFF;
            led_q      <= 8'hFF;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sel_q      <= sel_d;
            led_q      <= led_d;
            fd_q       <= fd_d;
        end
    end

    assign bus.seg_sel    = sel_q;
    assign bus.seg_led    = led_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a cycle-count based display model checked every cycle,
// directed load/boundary/reset scenarios with literal expectations, then random loads.
module tb_seg_scan_driver;

    localparam int unsigned SLOT  = 10;
    localparam int unsigned SHOWN = 8;
    localparam int unsigned FRAME = 80;

    logic clk = 1'b0;
    logic rst_n;

    seg_scan_driver_if bus ();

    seg_scan_driver #(
        .CLK_FREQ (1000),
        .SCAN_HZ  (100),
        .DEAD_CYC (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    logic [6:0] font_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    // Model: c counts clock edges since reset release; slot and phase follow from it.
    int unsigned c;
    logic [31:0] shd_nib, pnd_nib;
    logic [7:0]  shd_en, shd_dot, pnd_en, pnd_dot;
    bit          pflag;
    logic [7:0]  exp_sel, exp_led;
    logic        exp_fd;

    always @(posedge clk or negedge rst_n) begin
        int unsigned p;
        int unsigned digit;
        logic [3:0]  nib;
        if (!rst_n) begin
            c = 0; pflag = 0;
            shd_nib = '0; shd_en = '0; shd_dot = '0;
            pnd_nib = '0; pnd_en = '0; pnd_dot = '0;
            exp_sel = 8'hFF; exp_led = 8'hFF; exp_fd = 1'b0;
        end else begin
            p     = c % FRAME;
            digit = 7 - p / SLOT;
            exp_sel = 8'hFF;
            exp_led = 8'hFF;
            if ((p % SLOT) < SHOWN) begin
                exp_sel[digit] = 1'b0;
                nib = shd_nib[digit*4 +: 4];
                exp_led = {~shd_dot[digit], shd_en[digit] ? font_tbl[nib] : 7'h7F};
            end
            exp_fd = (p == FRAME - 1);
            if (p == FRAME - 1) begin
                if (bus.data_vld) begin
                    shd_nib = {bus.T_data, bus.H_data}; shd_en = bus.dat_en; shd_dot = bus.dot_en;
                end else if (pflag) begin
                    shd_nib = pnd_nib; shd_en = pnd_en; shd_dot = pnd_dot;
                end
                pflag = 0;
            end else if (bus.data_vld) begin
                pnd_nib = {bus.T_data, bus.H_data}; pnd_en = bus.dat_en; pnd_dot = bus.dot_en;
                pflag = 1;
            end
            c++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (bus.seg_sel !== exp_sel || bus.seg_led !== exp_led || bus.frame_done !== exp_fd) begin
                miscompares++;
                $display("FAIL model @%0t: sel=%h led=%h fd=%b, required sel=%h led=%h fd=%b",
                         $time, bus.seg_sel, bus.seg_led, bus.frame_done, exp_sel, exp_led, exp_fd);
            end
        end
    end

    task automatic check_eq(string name, logic [7:0] act, logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, required %h", name, $time, act, req);
        end
    endtask

    task automatic wait_digit(int d, output bit ok);
        logic [7:0] want;
        want    = 8'hFF;
        want[d] = 1'b0;
        ok      = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.seg_sel === want) ok = 1'b1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_digit%0d: timeout, sel=%h required %h", d, bus.seg_sel, want);
        end
    endtask

    task automatic check_digit(int d, logic [7:0] req);
        bit ok;
        wait_digit(d, ok);
        if (ok) check_eq($sformatf("digit%0d", d), bus.seg_led, req);
    endtask

    task automatic wait_frame();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_frame: timeout, frame_done=%b required 1", bus.frame_done);
        end
    endtask

    task automatic pulse(logic [15:0] t, logic [15:0] h, logic [7:0] en, logic [7:0] dot);
        bus.T_data   = t;
        bus.H_data   = h;
        bus.dat_en   = en;
        bus.dot_en   = dot;
        bus.data_vld = 1'b1;
        @(negedge clk);
        bus.data_vld = 1'b0;
    endtask

    initial begin
        int fd_cnt;
        int lit_cnt;
        bit ok;
        rst_n        = 1'b0;
        bus.T_data   = '0;
        bus.H_data   = '0;
        bus.dat_en   = '0;
        bus.dot_en   = '0;
        bus.data_vld = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check_eq("reset_sel", bus.seg_sel, 8'hFF);
        check_eq("reset_led", bus.seg_led, 8'hFF);
        check_eq("reset_fd", 8'(bus.frame_done), 8'h00);
        rst_n = 1'b1;

        // Two idle frames: blank segments, one frame_done per 80 cycles.
        fd_cnt  = 0;
        lit_cnt = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) fd_cnt++;
            if (bus.seg_led !== 8'hFF) lit_cnt++;
        end
        check_eq("idle_frame_done_count", 8'(fd_cnt), 8'd2);
        check_eq("idle_lit_cycles", 8'(lit_cnt), 8'd0);

        pulse(16'h0253, 16'h0456, 8'h7F, 8'h22);
        wait_frame();
        check_digit(7, 8'hFF); check_digit(6, 8'hA4); check_digit(5, 8'h12);
        check_digit(4, 8'hB0); check_digit(3, 8'hC0); check_digit(2, 8'h99);
        check_digit(1, 8'h12); check_digit(0, 8'h82);

        pulse(16'hA053, 16'h0456, 8'hBF, 8'h22);
        wait_frame();
        check_digit(7, 8'hBF); check_digit(6, 8'hFF); check_digit(5, 8'h12);

        // Mid-frame load must not disturb the remainder of the current frame.
        wait_digit(3, ok);
        pulse(16'h1111, 16'h9999, 8'hFF, 8'h00);
        check_digit(2, 8'h99); check_digit(1, 8'h12); check_digit(0, 8'h82);
        wait_frame();
        check_digit(7, 8'hF9);

        // Load exactly on the boundary cycle.
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (c % FRAME == FRAME - 1) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) check_eq("boundary_search", 8'h00, 8'h01);
        pulse(16'h8888, 16'h0000, 8'hFF, 8'h00);
        check_digit(7, 8'h80);

        for (int i = 0; i < 3000; i++) begin
            bus.data_vld = (($urandom % 40) == 0) ||
                           ((c % FRAME == FRAME - 1) && (($urandom % 2) == 0));
            if (bus.data_vld) begin
                bus.T_data = 16'($urandom);
                bus.H_data = 16'($urandom);
                bus.dat_en = 8'($urandom);
                bus.dot_en = 8'($urandom);
            end
            @(negedge clk);
        end
        bus.data_vld = 1'b0;

        // Asynchronous reset during digit 5 SHOW.
        wait_digit(5, ok);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_sel", bus.seg_sel, 8'hFF);
        check_eq("async_rst_led", bus.seg_led, 8'hFF);
        check_eq("async_rst_fd", 8'(bus.frame_done), 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_digit(7, 8'hFF);
        check_digit(6, 8'hFF);
        repeat (100) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
